// File: rtl/t5_wback.sv
// Writeback stage: arbitrates the single register-file write port between
// same-cycle ALU/link results and one outstanding (possibly delayed) load.
//
// state  | meaning
// S_IDLE | no load outstanding
// S_WAIT | load issued, waiting for dwb_ack
// S_DATA | load data aligned and held, waiting for a free write port
module t5_wback #(
  parameter int XLEN = 32
) (
  input  logic            sclk,
  input  logic            srst_n,
  input  logic            mvld,
  input  logic [1:0]      mhart,
  input  logic            mwb,
  input  logic [4:0]      mrd,
  input  logic [1:0]      msel,
  input  logic [1:0]      mlsz,
  input  logic            mlun,
  input  logic [1:0]      madr,
  input  logic [XLEN-1:0] malu,
  input  logic [XLEN-1:0] mpc,
  input  logic [XLEN-1:0] dwb_dti,
  input  logic            dwb_ack,
  output logic            mwre,
  output logic [4:0]      rd0a,
  output logic [XLEN-1:0] rd0d,
  output logic [1:0]      whart,
  output logic            ldbusy,
  output logic [1:0]      lhart,
  output logic            lerr
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;

  state_t          state;
  logic [1:0]      slot_hart;
  logic            slot_wb;
  logic [4:0]      slot_rd;
  logic [1:0]      slot_lsz;
  logic            slot_lun;
  logic [1:0]      slot_adr;
  logic [XLEN-1:0] ld_data;

  logic            is_load;
  logic            nl_claim;
  logic            slot_wr;
  logic [XLEN-1:0] nl_data;
  logic [XLEN-1:0] ld_ext;

  function automatic logic [XLEN-1:0] load_ext(
    input logic [XLEN-1:0] dti,
    input logic [1:0]      lsz,
    input logic            lun,
    input logic [1:0]      adr
  );
    logic [7:0]  b;
    logic [15:0] h;
    case (adr)
      2'd0:    b = dti[7:0];
      2'd1:    b = dti[15:8];
      2'd2:    b = dti[23:16];
      default: b = dti[31:24];
    endcase
    h = adr[1] ? dti[31:16] : dti[15:0];
    case (lsz)
      2'b00:   return {{(XLEN-8){b[7] & ~lun}}, b};
      2'b01:   return {{(XLEN-16){h[15] & ~lun}}, h};
      default: return dti;
    endcase
  endfunction

  always_comb begin
    is_load  = mvld && (msel == 2'b10);
    nl_claim = mvld && (msel != 2'b10) && mwb && (mrd != 5'd0);
    nl_data  = (msel == 2'b01) ? (mpc + XLEN'(4)) : malu;
    slot_wr  = slot_wb && (slot_rd != 5'd0);
    ld_ext   = load_ext(dwb_dti, slot_lsz, slot_lun, slot_adr);
  end

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state     <= S_IDLE;
      slot_hart <= '0;
      slot_wb   <= 1'b0;
      slot_rd   <= '0;
      slot_lsz  <= '0;
      slot_lun  <= 1'b0;
      slot_adr  <= '0;
      ld_data   <= '0;
      mwre      <= 1'b0;
      rd0a      <= '0;
      rd0d      <= '0;
      whart     <= '0;
      ldbusy    <= 1'b0;
      lhart     <= '0;
      lerr      <= 1'b0;
    end else begin
      mwre <= 1'b0;
      // Same-cycle results always win the port; load data waits behind them.
      if (nl_claim) begin
        mwre  <= 1'b1;
        rd0a  <= mrd;
        rd0d  <= nl_data;
        whart <= mhart;
      end

      case (state)
        S_IDLE: begin
          if (dwb_ack) lerr <= 1'b1;
          if (is_load) begin
            slot_hart <= mhart;
            slot_wb   <= mwb;
            slot_rd   <= mrd;
            slot_lsz  <= mlsz;
            slot_lun  <= mlun;
            slot_adr  <= madr;
            state     <= S_WAIT;
            ldbusy    <= 1'b1;
            lhart     <= mhart;
          end
        end

        S_WAIT: begin
          if (is_load) lerr <= 1'b1;
          if (dwb_ack) begin
            if (!slot_wr) begin
              state  <= S_IDLE;
              ldbusy <= 1'b0;
              lhart  <= '0;
            end else if (nl_claim) begin
              ld_data <= ld_ext;
              state   <= S_DATA;
            end else begin
              mwre   <= 1'b1;
              rd0a   <= slot_rd;
              rd0d   <= ld_ext;
              whart  <= slot_hart;
              state  <= S_IDLE;
              ldbusy <= 1'b0;
              lhart  <= '0;
            end
          end
        end

        S_DATA: begin
          if (is_load || dwb_ack) lerr <= 1'b1;
          if (!nl_claim) begin
            mwre   <= 1'b1;
            rd0a   <= slot_rd;
            rd0d   <= ld_data;
            whart  <= slot_hart;
            state  <= S_IDLE;
            ldbusy <= 1'b0;
            lhart  <= '0;
          end
        end

        default: begin
          state  <= S_IDLE;
          ldbusy <= 1'b0;
          lhart  <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/t5_wback.md
T5_WBACK -- requirements
Module: t5_wback

Interface
REQ-001 Parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 sclk  in  1  single clock; all state changes on its rising edge.
REQ-003 srst_n  in  1  reset; asynchronous, active-low.
REQ-004 mvld  in  1  M-stage instruction valid this cycle.
REQ-005 mhart  in  2  hart id of the M-stage instruction.
REQ-006 mwb  in  1  instruction writes a destination register.
REQ-007 mrd  in  5  destination register address.
REQ-008 msel  in  2  result source: 00 ALU, 01 link (PC+4), 10 load, 11 reserved (treated as ALU).
REQ-009 mlsz  in  2  load size: 00 byte, 01 half, 10 or 11 word.
REQ-010 mlun  in  1  load is unsigned (zero-extend).
REQ-011 madr  in  2  load address bits [1:0].
REQ-012 malu  in  XLEN  ALU result.
REQ-013 mpc  in  XLEN  PC of the M-stage instruction.
REQ-014 dwb_dti  in  XLEN  data bus read data, valid when dwb_ack=1.
REQ-015 dwb_ack  in  1  data bus load acknowledge.
REQ-016 mwre  out  1  register-file write enable (one-cycle pulse per write).
REQ-017 rd0a  out  5  register-file write address.
REQ-018 rd0d  out  XLEN  register-file write data.
REQ-019 whart  out  2  hart id of the register-file write.
REQ-020 ldbusy  out  1  a load is outstanding; issue logic stalls further loads.
REQ-021 lhart  out  2  hart that owns the outstanding load.
REQ-022 lerr  out  1  sticky protocol-error flag.

Function
REQ-023 FSM states: IDLE, WAIT (load issued, awaiting dwb_ack), DATA (load data captured, awaiting write port).
REQ-024 A load (mvld=1, msel=10) in IDLE captures mhart, mrd, mwb, mlsz, mlun, and madr into the load slot and moves to WAIT.
REQ-025 In WAIT, dwb_ack=1 aligns and extends dwb_dti and moves to IDLE if the port is free next cycle, otherwise to DATA with the data held.
REQ-026 In DATA, the held load result is written at the first free port cycle, then the FSM moves to IDLE.
REQ-027 ldbusy=1 in WAIT and DATA; lhart equals the load-slot hart while ldbusy=1, else 0.
REQ-028 The write port is claimed by a non-load instruction (mvld=1, msel!=10, mwb=1, mrd!=0) captured at the same edge; that instruction has priority over load data.
REQ-029 A non-load write appears exactly 1 cycle after its mvld cycle: mwre=1, rd0a=mrd, whart=mhart; rd0d=malu (msel 00/11) or mpc+4 modulo 2^XLEN (msel 01).
REQ-030 Load write latency: at best 1 cycle after dwb_ack; +1 cycle for each consecutive cycle the port is claimed by REQ-028.
REQ-031 Writes to x0 (rd=0) or with mwb=0 never assert mwre; a load with rd=0 still waits for dwb_ack, then returns to IDLE without writing.
REQ-032 Byte load: lane madr selects dti[8*madr+7:8*madr], sign-extended unless mlun=1.
REQ-033 Half load: madr[1] selects dti[31:16] or dti[15:0], sign-extended unless mlun=1; madr[0] is ignored.
REQ-034 Word load: dti is passed unchanged; madr is ignored.
REQ-035 mwre=0 on every cycle without a qualifying write; rd0a, rd0d, and whart hold their last values when mwre=0.
REQ-036 lerr is set and held on any of these events: a load issued while ldbusy=1 (that load is dropped), dwb_ack=1 in IDLE or DATA (that ack is ignored), or dwb_ack and a new load in the same cycle while IDLE.
REQ-037 In WAIT, a dwb_ack and a new non-load instruction in the same cycle are legal; REQ-028 and REQ-025 then apply.

Reset
REQ-038 While srst_n=0: FSM=IDLE, mwre=0, rd0a=0, rd0d=0, whart=0, ldbusy=0, lhart=0, lerr=0; the load slot is cleared.
REQ-039 Reset asserted mid-load discards the outstanding load; a dwb_ack after reset release sets lerr.

Verification
REQ-040 ALU and link writes: mvld, msel=00, mrd=5, malu=0x1234, hart 2, then msel=01 with mpc=0xFFFFFFFC -> mwre on the next two cycles with rd0d=0x1234/whart=2, then rd0d=0x00000000.
REQ-041 Load extension: byte load with madr=3, mlun=0, dti=0x80000000 -> rd0d=0xFFFFFF80; half load with madr=2, mlun=1 -> rd0d=0x00008000.
REQ-042 Port collision: dwb_ack in the same cycle as a non-load with mrd=7 -> rd7 is written first, the load result one cycle later, and FSM passes through DATA.
REQ-043 x0 suppression: ALU write to rd=0, and load to rd=0 acked -> mwre stays 0 throughout and ldbusy clears the cycle after ack.
REQ-044 Protocol errors: a second load while ldbusy=1 -> lerr=1 and stays 1; a spurious dwb_ack in IDLE -> lerr=1; only reset clears lerr.
REQ-045 Reset in WAIT: srst_n pulsed low -> all outputs 0 immediately (asynchronously); a later dwb_ack -> lerr=1 and mwre stays 0.
